acc_4_bit_seq: RTL and testbench

- Sequential accumulator sitting directly downstream of adder_4_bit; instantiates one adder_4_bit as its datapath.
- Adder A inputs are driven from the accumulator register and B inputs from the incoming operand; S3..S0 and C_out are registered back.
- Sums a block of N_OPS 4-bit operands received over a valid/ready stream, then presents the block result with a sticky overflow flag on a valid/ready output.

---
 rtl/acc_4_bit_seq.sv | 206 ++++++++++++++++++++
 tb/tb_acc_4_bit_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_4_bit_seq.sv
// -----------------------------------------------------------------------------
// acc_4_bit_seq
//   Sequential block accumulator built around one adder_4_bit. Operands arrive
//   on a valid/ready stream and are summed N_OPS at a time, or fewer when the
//   block is closed early with flush. The block result (sum, sticky carry
//   flag, operand count) is then held on a valid/ready output until the
//   consumer takes it.
//
//   Optional build macro: ACC4_SAT_EN
//     defined   - an add that carries out saturates the accumulator to 4'hF
//     undefined - modulo-16 wrap-around (default)
//   The overflow flag is reported in both builds.
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder used as the accumulator datapath.
module adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic c1_s;
  logic c2_s;
  logic c3_s;

  // Ripple the carry bit by bit through four full adders.
  always_comb begin
    s[0]  = a[0] ^ b[0] ^ c_in;
    c1_s  = (a[0] & b[0]) | (a[0] & c_in) | (b[0] & c_in);
    s[1]  = a[1] ^ b[1] ^ c1_s;
    c2_s  = (a[1] & b[1]) | (a[1] & c1_s) | (b[1] & c1_s);
    s[2]  = a[2] ^ b[2] ^ c2_s;
    c3_s  = (a[2] & b[2]) | (a[2] & c2_s) | (b[2] & c2_s);
    s[3]  = a[3] ^ b[3] ^ c3_s;
    c_out = (a[3] & b[3]) | (a[3] & c3_s) | (b[3] & c3_s);
  end

endmodule

module acc_4_bit_seq #(
  parameter int N_OPS = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS);

  state_t           state_r;
  logic [3:0]       acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;

  logic [3:0]       add_sum_s;
  logic             add_cout_s;
  logic [3:0]       acc_next_s;
  logic             ovf_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             accept_s;
  logic             close_on_accept_s;
  logic             close_empty_s;

  // Adder A side is the running total, B side is the incoming operand.
  adder_4_bit u_adder (
    .a     (acc_r),
    .b     (in_data),
    .c_in  (1'b0),
    .s     (add_sum_s),
    .c_out (add_cout_s)
  );

  // Next accumulator value; saturating build clamps on any carry out.
  always_comb begin
    acc_next_s = add_sum_s;
`ifdef ACC4_SAT_EN
    if (add_cout_s) begin
      acc_next_s = 4'hF;
    end else begin
      acc_next_s = add_sum_s;
    end
`else
    acc_next_s = add_sum_s;
`endif
  end

  // Accept / block-close decisions for the current cycle.
  always_comb begin
    ovf_next_s        = ovf_r | add_cout_s;
    cnt_next_s        = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    accept_s          = 1'b0;
    close_on_accept_s = 1'b0;
    close_empty_s     = 1'b0;
    if (state_r == ST_ACC) begin
      accept_s = in_valid;
      if (in_valid) begin
        // A same-cycle flush closes the block with this operand included.
        close_on_accept_s = (cnt_next_s == LAST_CNT) | flush;
        close_empty_s     = 1'b0;
      end else begin
        close_on_accept_s = 1'b0;
        // Flush on an empty block has nothing to report and is ignored.
        close_empty_s     = flush & (cnt_r != {CNT_W{1'b0}});
      end
    end else begin
      accept_s          = 1'b0;
      close_on_accept_s = 1'b0;
      close_empty_s     = 1'b0;
    end
  end

  // Block state machine with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ACC;
      acc_r     <= 4'h0;
      ovf_r     <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= 4'h0;
      out_ovf   <= 1'b0;
      out_count <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s) begin
            acc_r <= acc_next_s;
            ovf_r <= ovf_next_s;
            cnt_r <= cnt_next_s;
            if (close_on_accept_s) begin
              state_r   <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= acc_next_s;
              out_ovf   <= ovf_next_s;
              out_count <= cnt_next_s;
            end else begin
              state_r   <= ST_ACC;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end else if (close_empty_s) begin
            state_r   <= ST_HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_sum   <= acc_r;
            out_ovf   <= ovf_r;
            out_count <= cnt_r;
          end else begin
            state_r   <= ST_ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Result is frozen until taken; input side stays closed meanwhile.
          if (out_ready) begin
            state_r   <= ST_ACC;
            acc_r     <= 4'h0;
            ovf_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= 4'h0;
            out_ovf   <= 1'b0;
            out_count <= {CNT_W{1'b0}};
          end else begin
            state_r   <= ST_HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: recover to an empty accumulating block.
          state_r   <= ST_ACC;
          acc_r     <= 4'h0;
          ovf_r     <= 1'b0;
          cnt_r     <= {CNT_W{1'b0}};
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_sum   <= 4'h0;
          out_ovf   <= 1'b0;
          out_count <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_4_bit_seq.sv
// -----------------------------------------------------------------------------
// tb_acc_4_bit_seq
//   Directed scenarios with literal expectations, then randomized traffic.
//   A block-level model (integer running total, operand count, holding flag)
//   predicts every output on every cycle. Honors ACC4_SAT_EN like the design.
// -----------------------------------------------------------------------------
module tb_acc_4_bit_seq;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_sum;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Block-level reference state
  int m_total = 0;
  int m_cnt   = 0;
  bit m_hold  = 1'b0;

  acc_4_bit_seq #(.N_OPS(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_sum(input int total);
`ifdef ACC4_SAT_EN
    return (total > 15) ? 15 : total;
`else
    return total % 16;
`endif
  endfunction

  // Reference: what the block must contain after each clock edge.
  always @(posedge clk) begin : model
    int t;
    int c;
    bit h;
    t = m_total;
    c = m_cnt;
    h = m_hold;
    if (rst) begin
      t = 0; c = 0; h = 1'b0;
    end else if (!h) begin
      if (in_valid) begin
        t = t + int'(in_data);
        c = c + 1;
        if (c == N || flush) h = 1'b1;
      end else if (flush && c > 0) begin
        h = 1'b1;
      end
    end else if (out_ready) begin
      t = 0; c = 0; h = 1'b0;
    end
    m_total <= t;
    m_cnt   <= c;
    m_hold  <= h;
  end

  // Compare every output against the reference on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready",  int'(in_ready),  m_hold ? 0 : 1);
      chk("m_out_valid", int'(out_valid), m_hold ? 1 : 0);
      chk("m_out_sum",   int'(out_sum),   m_hold ? exp_sum(m_total) : 0);
      chk("m_out_ovf",   int'(out_ovf),   (m_hold && m_total > 15) ? 1 : 0);
      chk("m_out_count", int'(out_count), m_hold ? m_cnt : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b1;
    tick();
    cmp_en = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    rst = 1'b0;

    // 2,3,4,5 -> E, no overflow, count 4
    feed(4'd2); feed(4'd3); feed(4'd4); feed(4'd5);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_sum", int'(out_sum), 14);
    chk("t1_ovf", int'(out_ovf), 0);
    chk("t1_count", int'(out_count), 4);
    chk("t1_in_ready_hold", int'(in_ready), 0);
    tick();
    chk("t1_in_ready_back", int'(in_ready), 1);

    // 9,9,0,0 -> overflow
    feed(4'd9); feed(4'd9); feed(4'd0); feed(4'd0);
`ifdef ACC4_SAT_EN
    chk("t2_sum", int'(out_sum), 15);
`else
    chk("t2_sum", int'(out_sum), 2);
`endif
    chk("t2_ovf", int'(out_ovf), 1);
    tick();

    // Stalled consumer: result held, inputs refused
    out_ready = 1'b0;
    feed(4'd1); feed(4'd2); feed(4'd3); feed(4'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'd7;
      tick();
      chk("t3_valid_held", int'(out_valid), 1);
      chk("t3_sum_held", int'(out_sum), 10);
      chk("t3_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t3_released", int'(in_ready), 1);

    // Flush after two operands
    feed(4'd1); feed(4'd6);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_a_sum", int'(out_sum), 7);
    chk("fl_a_count", int'(out_count), 2);
    tick();

    // Flush with the only operand in the same cycle
    flush = 1'b1; feed(4'd3); flush = 1'b0;
    chk("fl_b_sum", int'(out_sum), 3);
    chk("fl_b_count", int'(out_count), 1);
    tick();

    // Flush on an empty block does nothing
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_c_valid", int'(out_valid), 0);
    chk("fl_c_in_ready", int'(in_ready), 1);

    // Reset mid-block, then mid-hold
    feed(4'd1); feed(4'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_a_valid", int'(out_valid), 0);
    chk("rs_a_count", int'(out_count), 0);
    chk("rs_a_in_ready", int'(in_ready), 1);
    out_ready = 1'b0;
    feed(4'd2); feed(4'd2); feed(4'd2); feed(4'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rs_b_valid", int'(out_valid), 0);
    chk("rs_b_sum", int'(out_sum), 0);
    chk("rs_b_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    feed(4'd1); feed(4'd1); feed(4'd1); feed(4'd1);
    chk("rs_c_sum", int'(out_sum), 4);
    chk("rs_c_count", int'(out_count), 4);
    tick();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
